// File: rtl/rs_param_station.sv
// rs_param_station: Tomasulo reservation station with CDB snoop,
// dispatch bypass and oldest-ready issue over a valid/ready port.
module rs_param_station #(
  parameter int DEPTH       = 4,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 4,
  parameter int OP_W        = 2,
  parameter int RS_BASE_TAG = 1
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       disp_valid,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [DATA_W-1:0]          disp_v1,
  input  logic [TAG_W-1:0]           disp_q1,
  input  logic [DATA_W-1:0]          disp_v2,
  input  logic [TAG_W-1:0]           disp_q2,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [DATA_W-1:0]          iss_v1,
  output logic [DATA_W-1:0]          iss_v2,
  output logic [TAG_W-1:0]           iss_tag
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  busy;
  logic [OP_W-1:0]   op_r [DEPTH];
  logic [DATA_W-1:0] v1_r [DEPTH];
  logic [DATA_W-1:0] v2_r [DEPTH];
  logic [TAG_W-1:0]  q1_r [DEPTH];
  logic [TAG_W-1:0]  q2_r [DEPTH];
  // older[i][j]: entry j was allocated before entry i
  logic [DEPTH-1:0]  older [DEPTH];

  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  oldest;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     free_idx;
  logic              cdb_hit;
  logic              disp_fire;
  logic              iss_fire;
  logic              byp1;
  logic              byp2;

  always_comb begin
    ready  = '0;
    oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i] && (q1_r[i] == '0)
                 && (q2_r[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = ready[i] && !(|(ready & older[i]));
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(busy[i]);
    end
  end

  assign full      = &busy;
  assign iss_valid = |ready;
  assign iss_fire  = iss_valid && iss_ready;
  assign disp_fire = disp_valid && !full;
  assign cdb_hit   = cdb_valid && (cdb_tag != '0);
  assign byp1      = cdb_hit && (disp_q1 == cdb_tag);
  assign byp2      = cdb_hit && (disp_q2 == cdb_tag);

  always_comb begin
    iss_op  = '0;
    iss_v1  = '0;
    iss_v2  = '0;
    iss_tag = '0;
    if (iss_valid) begin
      iss_op  = op_r[sel_idx];
      iss_v1  = v1_r[sel_idx];
      iss_v2  = v2_r[sel_idx];
      iss_tag = TAG_W'(RS_BASE_TAG) + TAG_W'(sel_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (RST || flush) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && cdb_hit) begin
          if (q1_r[i] == cdb_tag) begin
            q1_r[i] <= '0;
            v1_r[i] <= cdb_data;
          end
          if (q2_r[i] == cdb_tag) begin
            q2_r[i] <= '0;
            v2_r[i] <= cdb_data;
          end
        end
      end
      if (iss_fire) busy[sel_idx] <= 1'b0;
      if (disp_fire) begin
        busy[free_idx] <= 1'b1;
        op_r[free_idx] <= disp_op;
        q1_r[free_idx] <= byp1 ? '0 : disp_q1;
        v1_r[free_idx] <= byp1 ? cdb_data : disp_v1;
        q2_r[free_idx] <= byp2 ? '0 : disp_q2;
        v2_r[free_idx] <= byp2 ? cdb_data : disp_v2;
        // new entry is younger than every live one
        older[free_idx] <= busy;
        for (int j = 0; j < DEPTH; j++) begin
          older[j][free_idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_param_station.sv
// tb_rs_param_station: per-cycle vector table plus a
// hand-written CDB wakeup sequence.
module tb_rs_param_station;

  logic        clk = 1'b0;
  logic        RST, flush, disp_valid;
  logic [1:0]  disp_op;
  logic [31:0] disp_v1, disp_v2;
  logic [3:0]  disp_q1, disp_q2;
  logic        full;
  logic [2:0]  count;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        iss_valid, iss_ready;
  logic [1:0]  iss_op;
  logic [31:0] iss_v1, iss_v2;
  logic [3:0]  iss_tag;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  rs_param_station dut (
    .clk(clk), .RST(RST), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_v1(disp_v1), .disp_q1(disp_q1),
    .disp_v2(disp_v2), .disp_q2(disp_q2),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_v1(iss_v1),
    .iss_v2(iss_v2), .iss_tag(iss_tag)
  );

  typedef struct {
    logic        rst, fl, dv, ir;
    logic [1:0]  op;
    logic [31:0] v1, v2;
    logic [3:0]  q1, q2;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        ef;
    logic [2:0]  ec;
    logic        eiv;
    logic [1:0]  eop;
    logic [31:0] ev1, ev2;
    logic [3:0]  etg;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t row(
    input int rst, fl, dv, ir,
    input int op, v1, q1, v2, q2,
    input int cv, ct, cd,
    input int ef, ec, eiv, eop, ev1, ev2, etg);
    vec_t r;
    r.rst = 1'(rst); r.fl = 1'(fl);
    r.dv = 1'(dv); r.ir = 1'(ir);
    r.op = 2'(op); r.v1 = 32'(v1); r.q1 = 4'(q1);
    r.v2 = 32'(v2); r.q2 = 4'(q2);
    r.cv = 1'(cv); r.ct = 4'(ct); r.cd = 32'(cd);
    r.ef = 1'(ef); r.ec = 3'(ec); r.eiv = 1'(eiv);
    r.eop = 2'(eop); r.ev1 = 32'(ev1);
    r.ev2 = 32'(ev2); r.etg = 4'(etg);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic idle_in();
    RST = 0; flush = 0; disp_valid = 0; disp_op = 0;
    disp_v1 = 0; disp_q1 = 0; disp_v2 = 0; disp_q2 = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    iss_ready = 0;
  endtask

  task automatic chk_out(input string p, input vec_t r);
    chk({p, ".full"}, 64'(full), 64'(r.ef));
    chk({p, ".cnt"},  64'(count), 64'(r.ec));
    chk({p, ".ivld"}, 64'(iss_valid), 64'(r.eiv));
    chk({p, ".op"},   64'(iss_op), 64'(r.eop));
    chk({p, ".v1"},   64'(iss_v1), 64'(r.ev1));
    chk({p, ".v2"},   64'(iss_v2), 64'(r.ev2));
    chk({p, ".tag"},  64'(iss_tag), 64'(r.etg));
  endtask

  initial begin
    vec_t z;
    int k;
    // T1: single ready op, then issue
    vt.push_back(row(0,0,1,0, 1,'h5,0,'h7,0, 0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,1,1,1,5,7,1));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    // T2: A waits on tag 9, B overtakes
    vt.push_back(row(0,0,1,0, 2,0,9,'h11,0, 0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,1,0, 3,'h21,0,'h22,0, 0,0,0, 0,1,0,0,0,0,0));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,2,1,3,'h21,'h22,2));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 1,9,'h33, 0,1,0,0,0,0,0));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,1,1,2,'h33,'h11,1));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,1,1,2,'h33,'h11,1));
    // T3: dispatch bypass on both sources
    vt.push_back(row(0,0,1,0, 1,0,6,0,6, 1,6,'hAA, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,1,1,1,'hAA,'hAA,1));
    // T4: fill, drop when full, cdb tag 0 ignored
    vt.push_back(row(0,0,1,0, 0,1,0,2,0, 0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,1,0, 1,3,0,4,0, 1,0,'hEE, 0,1,1,0,1,2,1));
    vt.push_back(row(0,0,1,0, 2,5,0,6,0, 0,0,0, 0,2,1,0,1,2,1));
    vt.push_back(row(0,0,1,0, 3,7,0,8,0, 0,0,0, 0,3,1,0,1,2,1));
    vt.push_back(row(0,0,1,0, 1,9,0,'hA,0, 0,0,0, 1,4,1,0,1,2,1));
    vt.push_back(row(0,0,1,1, 1,9,0,'hA,0, 0,0,0, 1,4,1,0,1,2,1));
    vt.push_back(row(0,0,1,0, 1,9,0,'hA,0, 0,0,0, 0,3,1,1,3,4,2));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 1,4,1,1,3,4,2));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 1,4,1,1,3,4,2));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,3,1,2,5,6,3));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,2,1,3,7,8,4));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,1,1,1,9,'hA,1));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    // T5: allocation order 2,0,1 issues tags 3,1,2
    vt.push_back(row(0,0,1,0, 1,'h10,0,'h11,0, 0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,1,0, 2,'h20,0,'h21,0, 0,0,0, 0,1,1,1,'h10,'h11,1));
    vt.push_back(row(0,0,1,0, 3,0,8,'h31,0, 0,0,0, 0,2,1,1,'h10,'h11,1));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,3,1,1,'h10,'h11,1));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,2,1,2,'h20,'h21,2));
    vt.push_back(row(0,0,1,0, 0,'h40,0,'h41,0, 0,0,0, 0,1,0,0,0,0,0));
    vt.push_back(row(0,0,1,0, 1,'h50,0,'h51,0, 0,0,0, 0,2,1,0,'h40,'h41,1));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 1,8,'h30, 0,3,1,0,'h40,'h41,1));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,3,1,3,'h30,'h31,3));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,2,1,0,'h40,'h41,1));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,1,1,1,'h50,'h51,2));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    // T6: flush with dispatch and issue pending
    vt.push_back(row(0,0,1,0, 1,1,0,2,0, 0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,1,0, 2,3,0,4,5, 0,0,0, 0,1,1,1,1,2,1));
    vt.push_back(row(0,0,1,0, 3,6,0,7,0, 0,0,0, 0,2,1,1,1,2,1));
    vt.push_back(row(0,1,1,1, 0,8,0,9,0, 0,0,0, 0,3,1,1,1,2,1));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    // reset mid-fill, then normal reuse
    vt.push_back(row(0,0,1,0, 1,1,0,2,0, 0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,1,0, 2,3,0,4,0, 0,0,0, 0,1,1,1,1,2,1));
    vt.push_back(row(1,0,1,1, 3,5,0,6,0, 0,0,0, 0,2,1,1,1,2,1));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,1,0, 2,'hB,0,'hC,0, 0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,1,1,2,'hB,'hC,1));
    vt.push_back(row(0,0,0,1, 0,0,0,0,0, 0,0,0, 0,1,1,2,'hB,'hC,1));
    vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));

    idle_in();
    RST = 1;
    repeat (2) @(negedge clk);
    RST = 0;
    #1;
    z = row(0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0);
    chk_out("reset", z);

    foreach (vt[i]) begin
      @(negedge clk);
      RST = vt[i].rst;  flush = vt[i].fl;
      disp_valid = vt[i].dv; disp_op = vt[i].op;
      disp_v1 = vt[i].v1; disp_q1 = vt[i].q1;
      disp_v2 = vt[i].v2; disp_q2 = vt[i].q2;
      cdb_valid = vt[i].cv; cdb_tag = vt[i].ct;
      cdb_data = vt[i].cd; iss_ready = vt[i].ir;
      #1;
      chk_out($sformatf("row%0d", i), vt[i]);
    end

    // wakeup: capture at one edge, presented right after
    @(negedge clk);
    idle_in();
    disp_valid = 1; disp_op = 2;
    disp_q1 = 3; disp_v2 = 'h5;
    @(negedge clk);
    idle_in();
    cdb_valid = 1; cdb_tag = 3; cdb_data = 'h77;
    #1;
    chk("wake.pre_ivld", 64'(iss_valid), 64'(0));
    chk("wake.pre_cnt", 64'(count), 64'(1));
    @(negedge clk);
    idle_in();
    #1;
    k = 0;
    while (!iss_valid && k < 5) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("wake.latency", 64'(k), 64'(0));
    chk("wake.v1", 64'(iss_v1), 64'('h77));
    chk("wake.v2", 64'(iss_v2), 64'('h5));
    chk("wake.tag", 64'(iss_tag), 64'(1));
    iss_ready = 1;
    @(negedge clk);
    idle_in();
    #1;
    chk("wake.drain_cnt", 64'(count), 64'(0));
    chk("wake.drain_ivld", 64'(iss_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
